// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, control enums and the control bundle.
package rv32_pkg;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10,
    ALU_IALU   = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic    regwrite;
    logic    memread;
    logic    memwrite;
    logic    branch;
    logic    jump;
    logic    jalr;
    logic    alusrc;
    logic    asel_pc;
    logic    illegal;
    aluop_e  aluop;
    wb_sel_e wb_sel;
  } ctrl_t;

  // All-zero bundle: what a bubble or a FENCE carries.
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I decoder: instruction word to control bundle,
// source-register usage flags and sign-extended immediate.
import rv32_pkg::*;

module ctrl_decode #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output ctrl_t           ctrl,
  output logic            rs1_used,
  output logic            rs2_used,
  output logic [XLEN-1:0] imm
);

  logic [6:0]         opcode;
  logic [4:0]         rd;
  imm_fmt_e           fmt;
  logic signed [31:0] imm32;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];

  // Opcode map: control bits, which sources are read, and immediate format.
  always_comb begin
    ctrl     = CTRL_NOP;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    fmt      = IMM_NONE;
    case (opcode)
      OPC_OP: begin
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALU_RTYPE;
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_IALU;
        rs1_used      = 1'b1;
        fmt           = IMM_I;
      end
      OPC_LOAD: begin
        ctrl.regwrite = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.wb_sel   = WB_MEM;
        rs1_used      = 1'b1;
        fmt           = IMM_I;
      end
      OPC_STORE: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
        fmt           = IMM_S;
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.aluop  = ALU_BRANCH;
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
        fmt         = IMM_B;
      end
      OPC_JAL: begin
        ctrl.regwrite = 1'b1;
        ctrl.jump     = 1'b1;
        ctrl.wb_sel   = WB_PC4;
        fmt           = IMM_J;
      end
      OPC_JALR: begin
        ctrl.regwrite = 1'b1;
        ctrl.jalr     = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.wb_sel   = WB_PC4;
        rs1_used      = 1'b1;
        fmt           = IMM_I;
      end
      OPC_LUI: begin
        ctrl.regwrite = 1'b1;
        ctrl.wb_sel   = WB_IMM;
        fmt           = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.asel_pc  = 1'b1;
        fmt           = IMM_U;
      end
      OPC_MISC_MEM: begin
        ctrl = CTRL_NOP;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
    if (rd == 5'd0) begin
      ctrl.regwrite = 1'b0;
    end
  end

  // Immediate assembly in 32 bits; the signed cast below extends it to XLEN.
  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered decode stage: owns the ID/EX handshake, load-use hazard
// detection, the ID/EX register and the saturating stall counter.
import rv32_pkg::*;

module decode_ctrl_stage #(
  parameter int XLEN        = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid,
  input  logic [31:0]            if_instr,
  input  logic [XLEN-1:0]        if_pc,
  output logic                   id_ready,
  input  logic                   flush,
  input  logic                   ex_ready,
  output logic                   ex_valid,
  output logic                   ex_regwrite,
  output logic                   ex_memread,
  output logic                   ex_memwrite,
  output logic                   ex_branch,
  output logic                   ex_jump,
  output logic                   ex_jalr,
  output logic                   ex_alusrc,
  output logic                   ex_asel_pc,
  output logic                   ex_illegal,
  output logic [1:0]             ex_aluop,
  output logic [1:0]             ex_wb_sel,
  output logic [REG_ADDR_W-1:0]  ex_rs1,
  output logic [REG_ADDR_W-1:0]  ex_rs2,
  output logic [REG_ADDR_W-1:0]  ex_rd,
  output logic [2:0]             ex_funct3,
  output logic                   ex_funct7b5,
  output logic [XLEN-1:0]        ex_imm,
  output logic [XLEN-1:0]        ex_pc,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

  ctrl_t                   dec_ctrl;
  logic                    dec_rs1_used;
  logic                    dec_rs2_used;
  logic [XLEN-1:0]         dec_imm;
  logic [REG_ADDR_W-1:0]   dec_rs1;
  logic [REG_ADDR_W-1:0]   dec_rs2;
  logic [REG_ADDR_W-1:0]   dec_rd;
  logic                    hazard;
  logic                    accept;

  ctrl_t                   ctrl_q;
  logic                    valid_q;
  logic [REG_ADDR_W-1:0]   rs1_q;
  logic [REG_ADDR_W-1:0]   rs2_q;
  logic [REG_ADDR_W-1:0]   rd_q;
  logic [2:0]              funct3_q;
  logic                    funct7b5_q;
  logic [XLEN-1:0]         imm_q;
  logic [XLEN-1:0]         pc_q;
  logic [STALL_CNT_W-1:0]  cnt_q;

  ctrl_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr    (if_instr),
    .ctrl     (dec_ctrl),
    .rs1_used (dec_rs1_used),
    .rs2_used (dec_rs2_used),
    .imm      (dec_imm)
  );

  assign dec_rs1 = REG_ADDR_W'(if_instr[19:15]);
  assign dec_rs2 = REG_ADDR_W'(if_instr[24:20]);
  assign dec_rd  = REG_ADDR_W'(if_instr[11:7]);

  assign hazard = valid_q & ctrl_q.memread & (rd_q != '0) &
                  ((dec_rs1_used & (dec_rs1 == rd_q)) |
                   (dec_rs2_used & (dec_rs2 == rd_q)));

  assign id_ready = !flush & !hazard & (!valid_q | ex_ready);
  assign accept   = if_valid & id_ready;

  // ID/EX register: flush beats back-pressure, back-pressure beats a new accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      ctrl_q     <= CTRL_NOP;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
      imm_q      <= '0;
      pc_q       <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NOP;
    end else if (valid_q && !ex_ready) begin
      valid_q <= valid_q;
    end else if (accept) begin
      valid_q    <= 1'b1;
      ctrl_q     <= dec_ctrl;
      rs1_q      <= dec_rs1;
      rs2_q      <= dec_rs2;
      rd_q       <= dec_rd;
      funct3_q   <= if_instr[14:12];
      funct7b5_q <= if_instr[30];
      imm_q      <= dec_imm;
      pc_q       <= if_pc;
    end else begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NOP;
    end
  end

  // Count cycles a valid instruction is held back by a load-use hazard, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (if_valid && hazard && !flush && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_regwrite = ctrl_q.regwrite;
  assign ex_memread  = ctrl_q.memread;
  assign ex_memwrite = ctrl_q.memwrite;
  assign ex_branch   = ctrl_q.branch;
  assign ex_jump     = ctrl_q.jump;
  assign ex_jalr     = ctrl_q.jalr;
  assign ex_alusrc   = ctrl_q.alusrc;
  assign ex_asel_pc  = ctrl_q.asel_pc;
  assign ex_illegal  = ctrl_q.illegal;
  assign ex_aluop    = ctrl_q.aluop;
  assign ex_wb_sel   = ctrl_q.wb_sel;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_funct3   = funct3_q;
  assign ex_funct7b5 = funct7b5_q;
  assign ex_imm      = imm_q;
  assign ex_pc       = pc_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage with hand-computed expectations.
// The stall counter is narrowed to 4 bits so saturation is reachable quickly.
module tb_decode_ctrl_stage;

  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int SCW  = 4;

  localparam logic [31:0] I_ADDI_X1_5 = 32'h00500093;
  localparam logic [31:0] I_ADDI_X2_7 = 32'h00700113;
  localparam logic [31:0] I_LW_X2     = 32'h0000A103;
  localparam logic [31:0] I_ADD_X3    = 32'h002101B3;
  localparam logic [31:0] I_LUI_X5    = 32'h123452B7;
  localparam logic [31:0] I_ADDI_X0   = 32'h00100013;
  localparam logic [31:0] I_ALL_ONES  = 32'hFFFFFFFF;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            if_valid = 1'b0;
  logic [31:0]     if_instr = '0;
  logic [XLEN-1:0] if_pc = '0;
  logic            id_ready;
  logic            flush = 1'b0;
  logic            ex_ready = 1'b0;
  logic            ex_valid;
  logic            ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jump;
  logic            ex_jalr, ex_alusrc, ex_asel_pc, ex_illegal;
  logic [1:0]      ex_aluop, ex_wb_sel;
  logic [RAW-1:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]      ex_funct3;
  logic            ex_funct7b5;
  logic [XLEN-1:0] ex_imm, ex_pc;
  logic [SCW-1:0]  stall_count;

  int checks = 0;
  int errors = 0;

  decode_ctrl_stage #(
    .XLEN        (XLEN),
    .REG_ADDR_W  (RAW),
    .STALL_CNT_W (SCW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .id_ready    (id_ready),
    .flush       (flush),
    .ex_ready    (ex_ready),
    .ex_valid    (ex_valid),
    .ex_regwrite (ex_regwrite),
    .ex_memread  (ex_memread),
    .ex_memwrite (ex_memwrite),
    .ex_branch   (ex_branch),
    .ex_jump     (ex_jump),
    .ex_jalr     (ex_jalr),
    .ex_alusrc   (ex_alusrc),
    .ex_asel_pc  (ex_asel_pc),
    .ex_illegal  (ex_illegal),
    .ex_aluop    (ex_aluop),
    .ex_wb_sel   (ex_wb_sel),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .ex_rd       (ex_rd),
    .ex_funct3   (ex_funct3),
    .ex_funct7b5 (ex_funct7b5),
    .ex_imm      (ex_imm),
    .ex_pc       (ex_pc),
    .stall_count (stall_count)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [31:0] instr,
                               input logic [31:0] pc, input logic fl,
                               input logic er);
    if_valid = v;
    if_instr = instr;
    if_pc    = pc;
    flush    = fl;
    ex_ready = er;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_valid",    64'(ex_valid),    64'd0);
    checkOutput("rst_regwrite", 64'(ex_regwrite), 64'd0);
    checkOutput("rst_aluop",    64'(ex_aluop),    64'd0);
    checkOutput("rst_wbsel",    64'(ex_wb_sel),   64'd0);
    checkOutput("rst_imm",      64'(ex_imm),      64'd0);
    checkOutput("rst_rd",       64'(ex_rd),       64'd0);
    checkOutput("rst_cnt",      64'(stall_count), 64'd0);
    checkOutput("rst_idready",  64'(id_ready),    64'd1);

    // addi x1,x0,5
    applyStimulus(1'b1, I_ADDI_X1_5, 32'h100, 1'b0, 1'b1);
    tick();
    checkOutput("addi_valid",    64'(ex_valid),    64'd1);
    checkOutput("addi_regwrite", 64'(ex_regwrite), 64'd1);
    checkOutput("addi_alusrc",   64'(ex_alusrc),   64'd1);
    checkOutput("addi_aluop",    64'(ex_aluop),    64'd3);
    checkOutput("addi_rd",       64'(ex_rd),       64'd1);
    checkOutput("addi_imm",      64'(ex_imm),      64'd5);
    checkOutput("addi_pc",       64'(ex_pc),       64'h100);
    checkOutput("addi_memread",  64'(ex_memread),  64'd0);

    // lw x2,0(x1) then add x3,x2,x2: one bubble
    applyStimulus(1'b1, I_LW_X2, 32'h104, 1'b0, 1'b1);
    checkOutput("lw_idready", 64'(id_ready), 64'd1);
    tick();
    checkOutput("lw_memread", 64'(ex_memread), 64'd1);
    checkOutput("lw_rd",      64'(ex_rd),      64'd2);
    checkOutput("lw_wbsel",   64'(ex_wb_sel),  64'd1);
    checkOutput("lw_funct3",  64'(ex_funct3),  64'd2);
    applyStimulus(1'b1, I_ADD_X3, 32'h108, 1'b0, 1'b1);
    checkOutput("hz_idready", 64'(id_ready), 64'd0);
    tick();
    checkOutput("bub_valid",   64'(ex_valid),    64'd0);
    checkOutput("bub_memread", 64'(ex_memread),  64'd0);
    checkOutput("bub_regwr",   64'(ex_regwrite), 64'd0);
    checkOutput("bub_cnt",     64'(stall_count), 64'd1);
    checkOutput("bub_idready", 64'(id_ready),    64'd1);
    tick();
    checkOutput("add_valid", 64'(ex_valid),    64'd1);
    checkOutput("add_aluop", 64'(ex_aluop),    64'd2);
    checkOutput("add_rd",    64'(ex_rd),       64'd3);
    checkOutput("add_rs2",   64'(ex_rs2),      64'd2);
    checkOutput("add_pc",    64'(ex_pc),       64'h108);
    checkOutput("add_cnt",   64'(stall_count), 64'd1);

    // lui x5,0x12345 then addi x0,x0,1
    applyStimulus(1'b1, I_LUI_X5, 32'h10C, 1'b0, 1'b1);
    tick();
    checkOutput("lui_wbsel",  64'(ex_wb_sel),   64'd3);
    checkOutput("lui_imm",    64'(ex_imm),      64'h12345000);
    checkOutput("lui_regwr",  64'(ex_regwrite), 64'd1);
    checkOutput("lui_alusrc", 64'(ex_alusrc),   64'd0);
    applyStimulus(1'b1, I_ADDI_X0, 32'h110, 1'b0, 1'b1);
    tick();
    checkOutput("x0_valid", 64'(ex_valid),    64'd1);
    checkOutput("x0_regwr", 64'(ex_regwrite), 64'd0);
    checkOutput("x0_imm",   64'(ex_imm),      64'd1);

    // Back-pressure hold for three cycles
    applyStimulus(1'b1, I_ADDI_X1_5, 32'h114, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, I_ADDI_X2_7, 32'h118, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("hold_idready", 64'(id_ready), 64'd0);
      tick();
      checkOutput("hold_valid", 64'(ex_valid),    64'd1);
      checkOutput("hold_rd",    64'(ex_rd),       64'd1);
      checkOutput("hold_imm",   64'(ex_imm),      64'd5);
      checkOutput("hold_regwr", 64'(ex_regwrite), 64'd1);
      checkOutput("hold_pc",    64'(ex_pc),       64'h114);
    end
    applyStimulus(1'b1, I_ADDI_X2_7, 32'h118, 1'b0, 1'b1);
    checkOutput("rel_idready", 64'(id_ready), 64'd1);
    tick();
    checkOutput("rel_rd",  64'(ex_rd),  64'd2);
    checkOutput("rel_imm", 64'(ex_imm), 64'd7);

    // Flush while a valid instruction is presented
    applyStimulus(1'b1, I_LUI_X5, 32'h11C, 1'b1, 1'b1);
    checkOutput("fl_idready", 64'(id_ready), 64'd0);
    tick();
    checkOutput("fl_valid", 64'(ex_valid),    64'd0);
    checkOutput("fl_regwr", 64'(ex_regwrite), 64'd0);
    checkOutput("fl_alusrc",64'(ex_alusrc),   64'd0);
    checkOutput("fl_wbsel", 64'(ex_wb_sel),   64'd0);
    checkOutput("fl_imm",   64'(ex_imm),      64'd7);

    // Illegal opcode
    applyStimulus(1'b1, I_ALL_ONES, 32'h120, 1'b0, 1'b1);
    tick();
    checkOutput("ill_valid",   64'(ex_valid),    64'd1);
    checkOutput("ill_illegal", 64'(ex_illegal),  64'd1);
    checkOutput("ill_regwr",   64'(ex_regwrite), 64'd0);
    checkOutput("ill_memwr",   64'(ex_memwrite), 64'd0);
    checkOutput("ill_imm",     64'(ex_imm),      64'd0);

    // Flush and hazard together: flush wins, counter holds
    applyStimulus(1'b1, I_LW_X2, 32'h124, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, I_ADD_X3, 32'h128, 1'b1, 1'b1);
    tick();
    checkOutput("flhz_cnt",   64'(stall_count), 64'd1);
    checkOutput("flhz_valid", 64'(ex_valid),    64'd0);

    // Sustained hazard until the counter saturates
    applyStimulus(1'b1, I_LW_X2, 32'h12C, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, I_ADD_X3, 32'h130, 1'b0, 1'b0);
    checkOutput("sat_idready", 64'(id_ready), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("sat_cnt_mid", 64'(stall_count), 64'd6);
    for (int i = 0; i < 12; i++) tick();
    checkOutput("sat_cnt_max", 64'(stall_count), 64'hF);
    checkOutput("sat_valid",   64'(ex_valid),    64'd1);
    checkOutput("sat_rd",      64'(ex_rd),       64'd2);

    // Reset in the middle of a load-use stall
    rst = 1'b1;
    tick();
    checkOutput("rstst_valid",   64'(ex_valid),    64'd0);
    checkOutput("rstst_cnt",     64'(stall_count), 64'd0);
    checkOutput("rstst_memread", 64'(ex_memread),  64'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
